// File: rtl/sample_voice_mixer.sv
// Time-multiplexed oscillator mixer: once per audio sample, each voice is
// visited for one cycle, its waveform value is summed, and the scaled,
// saturated sum is registered onto audio_out with a one-cycle sample_valid.

// Waveform shaper for one voice, fed from the top bits of its phase.
module sample_voice_wave #(
    parameter int BIT_WIDTH = 24
) (
    input  logic [BIT_WIDTH-1:0] p,
    input  logic [1:0]           wave,
    input  logic                 enable,
    output logic [BIT_WIDTH-1:0] sample
);
    logic [BIT_WIDTH-1:0] tri_q;

    // Saw, square, triangle or silence; a disabled voice contributes zero.
    always_comb begin
        tri_q  = {(p[BIT_WIDTH-1] ? ~p[BIT_WIDTH-2:0] : p[BIT_WIDTH-2:0]), 1'b0};
        sample = '0;
        if (enable) begin
            case (wave)
                2'd0:    sample = {~p[BIT_WIDTH-1], p[BIT_WIDTH-2:0]};
                2'd1:    sample = p[BIT_WIDTH-1] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                                                 : {1'b0, {(BIT_WIDTH-1){1'b1}}};
                2'd2:    sample = {~tri_q[BIT_WIDTH-1], tri_q[BIT_WIDTH-2:0]};
                default: sample = '0;
            endcase
        end
    end
endmodule

module sample_voice_mixer #(
    parameter int BIT_WIDTH        = 24,
    parameter int VOICES           = 4,
    parameter int PHASE_WIDTH      = 32,
    parameter int TICKS_PER_SAMPLE = 384,
    parameter int MIX_SHIFT        = 1
) (
    input  logic                                          clock_16_934_400,
    input  logic                                          reset_l,
    input  logic                                          cfg_valid,
    output logic                                          cfg_ready,
    input  logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] cfg_voice,
    input  logic [PHASE_WIDTH-1:0]                        cfg_phase_inc,
    input  logic [1:0]                                    cfg_wave,
    input  logic                                          cfg_enable,
    output logic signed [BIT_WIDTH-1:0]                   audio_out,
    output logic                                          sample_valid,
    output logic                                          clip
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int AW = BIT_WIDTH + $clog2(VOICES) + 1;
    localparam int CW = (TICKS_PER_SAMPLE > 1) ? $clog2(TICKS_PER_SAMPLE) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(TICKS_PER_SAMPLE - 1);
    localparam logic [VW-1:0] VOICE_LAST = VW'(VOICES - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUTPUT = 2'd2} state_t;

    state_t                              state_q, state_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [VW-1:0]                       vidx_q, vidx_d;
    logic [VOICES-1:0][PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic [VOICES-1:0][PHASE_WIDTH-1:0]  inc_q, inc_d;
    logic [VOICES-1:0][1:0]              wave_q, wave_d;
    logic [VOICES-1:0]                   en_q, en_d;
    logic signed [AW-1:0]                acc_q, acc_d, acc_shr;
    logic [BIT_WIDTH-1:0]                audio_q, audio_d;
    logic                                valid_q, valid_d;
    logic                                clip_q, clip_d;
    logic [BIT_WIDTH-1:0]                voice_smp;
    logic                                tick;

    assign tick         = (cnt_q == CNT_LAST);
    assign audio_out    = audio_q;
    assign sample_valid = valid_q;
    assign clip         = clip_q;

    // Only the voice being visited this cycle needs a shaper.
    sample_voice_wave #(.BIT_WIDTH(BIT_WIDTH)) u_wave (
        .p      (phase_q[vidx_q][PHASE_WIDTH-1 -: BIT_WIDTH]),
        .wave   (wave_q[vidx_q]),
        .enable (en_q[vidx_q]),
        .sample (voice_smp)
    );

    // Sample timing, voice sequencing, accumulation, output scaling and config writes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        vidx_d    = vidx_q;
        phase_d   = phase_q;
        inc_d     = inc_q;
        wave_d    = wave_q;
        en_d      = en_q;
        acc_d     = acc_q;
        audio_d   = audio_q;
        clip_d    = clip_q;
        valid_d   = (state_q == OUTPUT);
        acc_shr   = acc_q >>> MIX_SHIFT;
        cfg_ready = (state_q != ACCUM);

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = ACCUM;
                    vidx_d  = '0;
                    acc_d   = '0;
                end
            end
            ACCUM: begin
                acc_d = acc_q + $signed({{(AW-BIT_WIDTH){voice_smp[BIT_WIDTH-1]}}, voice_smp});
                // The value above was taken from the phase before this step.
                if (en_q[vidx_q])
                    phase_d[vidx_q] = phase_q[vidx_q] + inc_q[vidx_q];
                if (vidx_q == VOICE_LAST)
                    state_d = OUTPUT;
                else
                    vidx_d = vidx_q + 1'b1;
            end
            OUTPUT: begin
                state_d = IDLE;
                if (acc_shr > SAT_MAX) begin
                    audio_d = SAT_MAX[BIT_WIDTH-1:0];
                    clip_d  = 1'b1;
                end else if (acc_shr < SAT_MIN) begin
                    audio_d = SAT_MIN[BIT_WIDTH-1:0];
                    clip_d  = 1'b1;
                end else begin
                    audio_d = acc_shr[BIT_WIDTH-1:0];
                    clip_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Writes never land during ACCUM, so they cannot collide with phase stepping.
        if (cfg_valid && cfg_ready && (int'(cfg_voice) < VOICES)) begin
            inc_d[cfg_voice]  = cfg_phase_inc;
            wave_d[cfg_voice] = cfg_wave;
            en_d[cfg_voice]   = cfg_enable;
            if (cfg_enable && !en_q[cfg_voice])
                phase_d[cfg_voice] = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vidx_q  <= '0;
            phase_q <= '0;
            inc_q   <= '0;
            wave_q  <= '0;
            en_q    <= '0;
            acc_q   <= '0;
            audio_q <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vidx_q  <= vidx_d;
            phase_q <= phase_d;
            inc_q   <= inc_d;
            wave_q  <= wave_d;
            en_q    <= en_d;
            acc_q   <= acc_d;
            audio_q <= audio_d;
            valid_q <= valid_d;
            clip_q  <= clip_d;
        end
    end
endmodule

// File: tb/tb_sample_voice_mixer.sv
// Scoreboard bench for sample_voice_mixer: stimulus pushes expected samples,
// monitors pop and compare on every sample_valid pulse.
module tb_sample_voice_mixer;
    logic        clk;
    logic        rst_n;
    logic        cfg_valid1, cfg_valid2;
    logic [2:0]  cfg_voice;
    logic [31:0] cfg_inc;
    logic [1:0]  cfg_wave;
    logic        cfg_en;
    logic        ready1, ready2, valid1, valid2, clip1, clip2;
    logic signed [23:0] audio1, audio2;

    typedef struct packed {
        logic [23:0] audio;
        logic        clip;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   checks = 0;
    int   passes = 0;

    sample_voice_mixer u_dut (
        .clock_16_934_400 (clk),
        .reset_l          (rst_n),
        .cfg_valid        (cfg_valid1),
        .cfg_ready        (ready1),
        .cfg_voice        (cfg_voice[1:0]),
        .cfg_phase_inc    (cfg_inc),
        .cfg_wave         (cfg_wave),
        .cfg_enable       (cfg_en),
        .audio_out        (audio1),
        .sample_valid     (valid1),
        .clip             (clip1)
    );

    // Five voices so that index 5 is a representable out-of-range voice.
    sample_voice_mixer #(.VOICES(5)) u_dut5 (
        .clock_16_934_400 (clk),
        .reset_l          (rst_n),
        .cfg_valid        (cfg_valid2),
        .cfg_ready        (ready2),
        .cfg_voice        (cfg_voice),
        .cfg_phase_inc    (cfg_inc),
        .cfg_wave         (cfg_wave),
        .cfg_enable       (cfg_en),
        .audio_out        (audio2),
        .sample_valid     (valid2),
        .clip             (clip2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input int sel, input int a, input logic c);
        exp_t e;
        e.audio = a[23:0];
        e.clip  = c;
        if (sel != 0) q2.push_back(e);
        else          q1.push_back(e);
    endtask

    // Returns at the falling edge where the selected DUT shows sample_valid.
    task automatic wait_pulse(input int sel, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((sel != 0) ? valid2 : valid1) && n < 1000);
        if (!((sel != 0) ? valid2 : valid1)) check("pulse timeout", 0, 1);
    endtask

    // Called at a falling edge; holds the request until accepted.
    task automatic cfg_write(input int sel, input logic [2:0] v, input logic [31:0] inc,
                             input logic [1:0] w, input logic en);
        int n;
        cfg_voice = v;
        cfg_inc   = inc;
        cfg_wave  = w;
        cfg_en    = en;
        if (sel != 0) cfg_valid2 = 1'b1;
        else          cfg_valid1 = 1'b1;
        n = 0;
        while (!((sel != 0) ? ready2 : ready1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("cfg handshake timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        cfg_valid1 = 1'b0;
        cfg_valid2 = 1'b0;
    endtask

    // Scoreboard monitor for the default-parameter DUT.
    always @(negedge clk) begin
        if (rst_n && valid1 && q1.size() > 0) begin
            e1 = q1.pop_front();
            check("dut audio_out", longint'(audio1), longint'($signed(e1.audio)));
            check("dut clip", longint'(clip1), longint'(e1.clip));
        end
    end

    // Scoreboard monitor for the five-voice DUT.
    always @(negedge clk) begin
        if (rst_n && valid2 && q2.size() > 0) begin
            e2 = q2.pop_front();
            check("dut5 audio_out", longint'(audio2), longint'($signed(e2.audio)));
            check("dut5 clip", longint'(clip2), longint'(e2.clip));
        end
    end

    initial begin
        int n, stall_first, stall_len, acc;
        rst_n = 1'b0;
        cfg_valid1 = 1'b0; cfg_valid2 = 1'b0;
        cfg_voice = '0; cfg_inc = '0; cfg_wave = '0; cfg_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset audio_out", longint'(audio1), 0);
        check("reset sample_valid", longint'(valid1), 0);
        check("reset clip", longint'(clip1), 0);
        check("reset cfg_ready", longint'(ready1), 1);

        // Idle: silent samples on a fixed cadence.
        push(0, 0, 1'b0);
        push(0, 0, 1'b0);
        rst_n = 1'b1;
        wait_pulse(0, n);
        check("first pulse edge after release", n, 389);
        wait_pulse(0, n);
        check("pulse period", n, 384);

        // Voice 0 saw, quarter-cycle steps.
        cfg_write(0, 3'd0, 32'h4000_0000, 2'd0, 1'b1);
        push(0, -4194304, 1'b0);
        push(0, -2097152, 1'b0);
        push(0, 0, 1'b0);
        push(0, 2097152, 1'b0);
        push(0, -4194304, 1'b0);
        repeat (5) wait_pulse(0, n);

        // All four square at phase 0: positive saturation.
        cfg_write(0, 3'd0, 32'h0, 2'd0, 1'b0);
        for (int v = 0; v < 4; v++) cfg_write(0, 3'(v), 32'h0, 2'd1, 1'b1);
        push(0, 8388607, 1'b1);
        wait_pulse(0, n);
        repeat (100) @(negedge clk);
        check("audio_out holds", longint'(audio1), 8388607);
        check("clip holds", longint'(clip1), 1);

        // Half-cycle steps on enabled voices: phase kept, alternating rails.
        for (int v = 0; v < 4; v++) cfg_write(0, 3'(v), 32'h8000_0000, 2'd1, 1'b1);
        push(0, 8388607, 1'b1);
        push(0, -8388608, 1'b1);
        repeat (2) wait_pulse(0, n);

        // Reset in the middle of accumulation.
        repeat (380) @(negedge clk);
        check("cfg_ready low in accum", longint'(ready1), 0);
        check("audio_out before reset", longint'(audio1), -8388608);
        rst_n = 1'b0;
        #1;
        check("async reset audio_out", longint'(audio1), 0);
        check("async reset clip", longint'(clip1), 0);
        check("async reset sample_valid", longint'(valid1), 0);
        check("async reset cfg_ready", longint'(ready1), 1);
        repeat (2) @(negedge clk);
        push(0, 0, 1'b0);
        rst_n = 1'b1;
        wait_pulse(0, n);
        check("pulse after mid-accum reset", n, 389);

        // Voice 2 triangle, quarter-cycle steps; hits -1 via floor shift of -2.
        cfg_write(0, 3'd2, 32'h4000_0000, 2'd2, 1'b1);
        push(0, -4194304, 1'b0);
        push(0, 0, 1'b0);
        push(0, 4194303, 1'b0);
        push(0, -1, 1'b0);
        repeat (4) wait_pulse(0, n);

        // Write landing in the tick cycle applies to that sample.
        cfg_write(0, 3'd2, 32'h0, 2'd0, 1'b0);
        repeat (377) @(negedge clk);
        check("cfg_ready in tick cycle", longint'(ready1), 1);
        cfg_write(0, 3'd0, 32'h0, 2'd1, 1'b1);
        push(0, 4194303, 1'b0);
        wait_pulse(0, n);

        // Silent waveform on an enabled voice changes nothing.
        cfg_write(0, 3'd1, 32'h1234_5678, 2'd3, 1'b1);
        push(0, 4194303, 1'b0);
        push(0, 4194303, 1'b0);
        repeat (2) wait_pulse(0, n);

        // Back-to-back writes streamed across a tick.
        cfg_write(0, 3'd0, 32'h0, 2'd0, 1'b0);
        cfg_write(0, 3'd1, 32'h0, 2'd0, 1'b0);
        push(0, 0, 1'b0);
        push(0, 0, 1'b0);
        wait_pulse(0, n);
        stall_first = -1;
        stall_len   = 0;
        acc         = 0;
        cfg_voice = 3'd0; cfg_inc = 32'd0; cfg_wave = 2'd0; cfg_en = 1'b0;
        cfg_valid1 = 1'b1;
        for (int j = 0; j < 390; j++) begin
            if (ready1) acc++;
            else begin
                if (stall_first < 0) stall_first = j;
                stall_len++;
            end
            @(negedge clk);
            cfg_voice = {1'b0, acc[1:0]};
            cfg_inc   = acc;
            cfg_wave  = acc[1:0];
        end
        cfg_valid1 = 1'b0;
        check("stall start cycle", stall_first, 379);
        check("stall length", stall_len, 4);
        check("writes accepted", acc, 386);

        // Out-of-range voice on the five-voice DUT is accepted and ignored.
        wait_pulse(1, n);
        cfg_write(1, 3'd5, 32'h0, 2'd1, 1'b1);
        push(1, 0, 1'b0);
        wait_pulse(1, n);
        cfg_write(1, 3'd4, 32'h0, 2'd1, 1'b1);
        push(1, 4194303, 1'b0);
        wait_pulse(1, n);

        repeat (2) @(negedge clk);
        check("dut scoreboard drained", q1.size(), 0);
        check("dut5 scoreboard drained", q2.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sample_voice_mixer.md
SAMPLE_VOICE_MIXER -- requirements
Module: sample_voice_mixer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 24, output sample width (signed two's complement).
REQ-002 SHALL have parameter VOICES, default 4, oscillator voice count (1..16).
REQ-003 SHALL have parameter PHASE_WIDTH, default 32, phase accumulator width (>= BIT_WIDTH).
REQ-004 SHALL have parameter TICKS_PER_SAMPLE, default 384 (16.9344 MHz / 44.1 kHz); it SHALL satisfy TICKS_PER_SAMPLE >= VOICES+2.
REQ-005 SHALL have parameter MIX_SHIFT, default 1, arithmetic right shift applied to the voice sum.
REQ-006 SHALL have port clock_16_934_400  input  1  system/audio clock, all logic on its rising edge.
REQ-007 SHALL have port reset_l  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port cfg_valid  input  1  voice config request.
REQ-009 SHALL have port cfg_ready  output  1  config accept.
REQ-010 SHALL have port cfg_voice  input  max(1,$clog2(VOICES))  target voice index.
REQ-011 SHALL have port cfg_phase_inc  input  PHASE_WIDTH  per-sample phase increment.
REQ-012 SHALL have port cfg_wave  input  2  waveform: 0 saw, 1 square, 2 triangle, 3 silence.
REQ-013 SHALL have port cfg_enable  input  1  voice enable.
REQ-014 SHALL have port audio_out  output  BIT_WIDTH  mixed signed sample, registered.
REQ-015 SHALL have port sample_valid  output  1  one-cycle pulse when audio_out updates.
REQ-016 SHALL have port clip  output  1  high while current audio_out was saturated.

Function
REQ-017 Sample counter SHALL count 0..TICKS_PER_SAMPLE-1 and wrap; an internal tick SHALL occur in the cycle the count equals TICKS_PER_SAMPLE-1; no derived clocks.
REQ-018 FSM SHALL have states IDLE, ACCUM, OUTPUT: IDLE->ACCUM on tick; ACCUM one cycle per voice, index 0..VOICES-1; ACCUM->OUTPUT after voice VOICES-1; OUTPUT->IDLE after one cycle.
REQ-019 Latency: tick at cycle T -> ACCUM cycles T+1..T+VOICES -> audio_out, clip updated and sample_valid=1 at cycle T+VOICES+1 only.
REQ-020 In ACCUM, voice v SHALL contribute a value from the top BIT_WIDTH bits p of its phase before increment; then its phase SHALL increment by its phase_inc modulo 2^PHASE_WIDTH.
REQ-021 Saw SHALL be p with its MSB inverted (interpreted as signed).
REQ-022 Square SHALL be +(2^(BIT_WIDTH-1)-1) when p MSB=0, else -2^(BIT_WIDTH-1).
REQ-023 Triangle SHALL be q={(p MSB ? ~p[W-2:0] : p[W-2:0]),1'b0} with its MSB inverted (signed).
REQ-024 Silence (wave 3) or disabled voice SHALL contribute 0; a disabled voice's phase SHALL hold.
REQ-025 Accumulator SHALL be BIT_WIDTH+$clog2(VOICES)+1 bits signed, cleared on ACCUM entry; no internal overflow.
REQ-026 In OUTPUT the sum SHALL be arithmetic-shifted right by MIX_SHIFT (floor), then saturated to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1]; clip=1 iff saturation occurred; audio_out and clip hold until the next OUTPUT.
REQ-027 cfg_ready SHALL be 0 in ACCUM and 1 in IDLE and OUTPUT; a write is accepted when cfg_valid&&cfg_ready.
REQ-028 An accepted write SHALL load phase_inc, wave and enable of cfg_voice at the next edge; if enable goes 0->1, that voice's phase SHALL clear to 0; if already enabled, phase SHALL be kept.
REQ-029 A write with cfg_voice >= VOICES SHALL be accepted and ignored.
REQ-030 A write accepted in the same cycle as a tick SHALL take effect for the sample starting at T+1.

Reset
REQ-031 When reset_l=0, asynchronously: counter=0, FSM=IDLE, all phases/increments=0, waves=0, enables=0, accumulator=0, audio_out=0, sample_valid=0, clip=0; cfg_ready=1 once in IDLE.
REQ-032 Reset mid-ACCUM SHALL abandon the sample without a sample_valid pulse; first tick SHALL occur TICKS_PER_SAMPLE cycles after reset_l rises.

Verification (defaults)
REQ-033 Reset, no writes -> sample_valid pulses every 384 cycles, first at edge 384+5 after release; audio_out=0, clip=0.
REQ-034 Voice 0 saw, inc=0x4000_0000, enable -> audio_out sequence -4194304, -2097152, 0, 2097152, -4194304; clip=0.
REQ-035 All 4 voices square, inc=0, enabled -> sum 33554428 >> 1 saturates: audio_out=8388607, clip=1.
REQ-036 cfg_valid held high across a tick -> cfg_ready=0 for exactly cycles T+1..T+4; write accepted at T+5; no dropped or duplicated write.
REQ-037 reset_l pulsed low at T+2 -> outputs 0 immediately, no pulse at T+5, next pulse 389 cycles after release.
REQ-038 Voice 1 wave=3 with inc nonzero, voice 5 write -> audio_out unaffected, handshake completes.
